// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types and helpers for the registered one-hot decoder.
//   dec_state_t   : FSM encoding used by decoder_n_sync (also visible on its
//                   State_Out debug port).
//   decode_onehot : returns a MAX_OUT_WIDTH-wide one-hot (or one-cold) vector
//                   for a code. Callers keep the low 2**SEL_WIDTH bits.
// -----------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2
  } dec_state_t;

  // Widest decoder this package supports.
  localparam int MAX_SEL_WIDTH = 8;
  localparam int MAX_OUT_WIDTH = 1 << MAX_SEL_WIDTH;

  // Full decode: every code value selects exactly one bit. With active_low set
  // the whole vector is inverted, so the selected bit is the only 0.
  function automatic logic [MAX_OUT_WIDTH-1:0] decode_onehot(
    input logic [MAX_SEL_WIDTH-1:0] code,
    input logic                     active_low
  );
    logic [MAX_OUT_WIDTH-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/decoder_pulse_timer.sv
// -----------------------------------------------------------------------------
// decoder_pulse_timer
// Load / decrement / expire counter that times the active phase of a pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load PULSE_LEN-1 (first active cycle is the load cycle's next)
//   run        : owner is in its pulse state; count down while nonzero
//   abort      : clear the counter; suppresses expire
//   expire     : run && counter at zero && no abort (pulse completes this edge)
//   zero       : counter is zero
// The counter is unsigned and saturates at zero; it never wraps.
// -----------------------------------------------------------------------------
module decoder_pulse_timer #(
  parameter  int PULSE_LEN = 1,
  localparam int CNT_W     = (PULSE_LEN < 1) ? 1 : $clog2(PULSE_LEN + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  input  logic abort,
  output logic expire,
  output logic zero
);

  // Level-mode instances never load, so the value only has to be legal.
  localparam int LOAD_VAL = (PULSE_LEN > 0) ? PULSE_LEN - 1 : 0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero   = (cnt == '0);
  assign expire = run && zero && !abort;

endmodule

// File: rtl/decoder_n_sync.sv
// -----------------------------------------------------------------------------
// decoder_n_sync
// Registered N-to-2^N one-hot decoder with a valid/ready input handshake.
// Level mode (PULSE_LEN=0) holds the last accepted code; pulse mode drives it
// for exactly PULSE_LEN cycles, then strobes Done_Out.
//   Clock_In         : clock, rising edge
//   Reset_In         : asynchronous active-low reset
//   Enable_In        : 0 clears the output and aborts a pulse
//   Valid_In         : Encoded_Value_In is valid
//   Encoded_Value_In : code to decode (SEL_WIDTH bits)
//   Ready_Out        : code can be accepted this cycle (combinational)
//   Decoded_Out      : registered one-hot / one-cold vector (OUT_WIDTH bits)
//   Active_Out       : an output bit is asserted (state != IDLE)
//   Done_Out         : one-cycle strobe after a pulse completes normally
//   State_Out        : current FSM state (debug)
//
// Handshake: a code is accepted on a rising edge where Valid_In && Ready_Out.
// Ready_Out = Enable_In && (state != PULSE) and does not depend on Valid_In.
// An accepted code appears on Decoded_Out in the cycle after that edge.
// -----------------------------------------------------------------------------
module decoder_n_sync
  import decoder_pkg::*;
#(
  parameter  int SEL_WIDTH      = 2,
  parameter  int PULSE_LEN      = 0,
  parameter  bit ACTIVE_LOW_OUT = 1'b0,
  localparam int OUT_WIDTH      = 2 ** SEL_WIDTH
) (
  input  logic                 Clock_In,
  input  logic                 Reset_In,
  input  logic                 Enable_In,
  input  logic                 Valid_In,
  input  logic [SEL_WIDTH-1:0] Encoded_Value_In,
  output logic                 Ready_Out,
  output logic [OUT_WIDTH-1:0] Decoded_Out,
  output logic                 Active_Out,
  output logic                 Done_Out,
  output logic [1:0]           State_Out
);

  localparam bit                 LEVEL_MODE = (PULSE_LEN == 0);
  localparam logic [OUT_WIDTH-1:0] INACTIVE = {OUT_WIDTH{ACTIVE_LOW_OUT}};

  dec_state_t             state;
  logic [OUT_WIDTH-1:0]   dec_q;
  logic                   done_q;
  logic                   accept;
  logic [MAX_OUT_WIDTH-1:0] decode_wide;
  logic [OUT_WIDTH-1:0]   decoded;
  logic                   unused_decode_hi;
  logic                   timer_expire;
  logic                   timer_zero;

  assign Ready_Out = Enable_In && (state != PULSE);
  assign accept    = Valid_In && Ready_Out;

  // Bits above OUT_WIDTH of the package-wide decode are never selected.
  assign decode_wide      = decode_onehot(MAX_SEL_WIDTH'(Encoded_Value_In), ACTIVE_LOW_OUT);
  assign decoded          = decode_wide[OUT_WIDTH-1:0];
  assign unused_decode_hi = ^decode_wide;

  decoder_pulse_timer #(
    .PULSE_LEN(PULSE_LEN)
  ) u_timer (
    .clk   (Clock_In),
    .rst_n (Reset_In),
    .load  (accept && (state == IDLE) && !LEVEL_MODE),
    .run   (state == PULSE),
    .abort (!Enable_In),
    .expire(timer_expire),
    .zero  (timer_zero)
  );

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state  <= IDLE;
      dec_q  <= INACTIVE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dec_q <= decoded;
            state <= LEVEL_MODE ? HOLD : PULSE;
          end
        end
        HOLD: begin
          if (!Enable_In) begin
            dec_q <= INACTIVE;
            state <= IDLE;
          end else if (accept) begin
            dec_q <= decoded;
          end
        end
        PULSE: begin
          // Abort wins over expiry on the same edge and never strobes Done.
          if (!Enable_In) begin
            dec_q <= INACTIVE;
            state <= IDLE;
          end else if (timer_zero) begin
            dec_q  <= INACTIVE;
            state  <= IDLE;
            done_q <= timer_expire;
          end
        end
        default: begin
          dec_q <= INACTIVE;
          state <= IDLE;
        end
      endcase
    end
  end

  assign Decoded_Out = dec_q;
  assign Done_Out    = done_q;
  assign Active_Out  = (state != IDLE);
  assign State_Out   = state;

endmodule

// File: tb/tb_decoder_n_sync.sv
// -----------------------------------------------------------------------------
// tb_decoder_n_sync
// Six decoder instances share one clock and reset:
//   0: SEL_WIDTH=2 PULSE_LEN=0 ACTIVE_LOW_OUT=1  (reset / polarity)
//   1: SEL_WIDTH=3 PULSE_LEN=0                   (level mode, random)
//   2: SEL_WIDTH=2 PULSE_LEN=3                   (pulse length)
//   3: SEL_WIDTH=2 PULSE_LEN=1                   (back-to-back, random)
//   4: SEL_WIDTH=2 PULSE_LEN=4                   (abort)
//   5: SEL_WIDTH=2 PULSE_LEN=5                   (random)
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_decoder_n_sync;
  import decoder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en   [6];
  logic       vld  [6];
  logic [2:0] code [6];
  logic       rdy  [6];
  logic       act  [6];
  logic       dn   [6];
  logic [1:0] st   [6];
  logic [7:0] dec  [6];

  logic [3:0] d0, d2, d3, d4, d5;
  logic [7:0] d1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  decoder_n_sync #(.SEL_WIDTH(2), .PULSE_LEN(0), .ACTIVE_LOW_OUT(1'b1)) u_al (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en[0]), .Valid_In(vld[0]),
    .Encoded_Value_In(code[0][1:0]), .Ready_Out(rdy[0]), .Decoded_Out(d0),
    .Active_Out(act[0]), .Done_Out(dn[0]), .State_Out(st[0]));

  decoder_n_sync #(.SEL_WIDTH(3), .PULSE_LEN(0), .ACTIVE_LOW_OUT(1'b0)) u_lvl (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en[1]), .Valid_In(vld[1]),
    .Encoded_Value_In(code[1]), .Ready_Out(rdy[1]), .Decoded_Out(d1),
    .Active_Out(act[1]), .Done_Out(dn[1]), .State_Out(st[1]));

  decoder_n_sync #(.SEL_WIDTH(2), .PULSE_LEN(3), .ACTIVE_LOW_OUT(1'b0)) u_p3 (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en[2]), .Valid_In(vld[2]),
    .Encoded_Value_In(code[2][1:0]), .Ready_Out(rdy[2]), .Decoded_Out(d2),
    .Active_Out(act[2]), .Done_Out(dn[2]), .State_Out(st[2]));

  decoder_n_sync #(.SEL_WIDTH(2), .PULSE_LEN(1), .ACTIVE_LOW_OUT(1'b0)) u_p1 (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en[3]), .Valid_In(vld[3]),
    .Encoded_Value_In(code[3][1:0]), .Ready_Out(rdy[3]), .Decoded_Out(d3),
    .Active_Out(act[3]), .Done_Out(dn[3]), .State_Out(st[3]));

  decoder_n_sync #(.SEL_WIDTH(2), .PULSE_LEN(4), .ACTIVE_LOW_OUT(1'b0)) u_p4 (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en[4]), .Valid_In(vld[4]),
    .Encoded_Value_In(code[4][1:0]), .Ready_Out(rdy[4]), .Decoded_Out(d4),
    .Active_Out(act[4]), .Done_Out(dn[4]), .State_Out(st[4]));

  decoder_n_sync #(.SEL_WIDTH(2), .PULSE_LEN(5), .ACTIVE_LOW_OUT(1'b0)) u_p5 (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en[5]), .Valid_In(vld[5]),
    .Encoded_Value_In(code[5][1:0]), .Ready_Out(rdy[5]), .Decoded_Out(d5),
    .Active_Out(act[5]), .Done_Out(dn[5]), .State_Out(st[5]));

  always_comb begin
    dec[0] = {4'b0, d0};
    dec[1] = d1;
    dec[2] = {4'b0, d2};
    dec[3] = {4'b0, d3};
    dec[4] = {4'b0, d4};
    dec[5] = {4'b0, d5};
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    total_cnt++; if (dec[0] !== 8'h0F) $display("FAIL reset_dec_al: got %h expected %h", dec[0], 8'h0F); else pass_cnt++;
    total_cnt++; if (act[0] !== 1'b0) $display("FAIL reset_act_al: got %b expected 0", act[0]); else pass_cnt++;
    total_cnt++; if (dn[0] !== 1'b0) $display("FAIL reset_done_al: got %b expected 0", dn[0]); else pass_cnt++;
    total_cnt++; if (dec[1] !== 8'h00) $display("FAIL reset_dec_lvl: got %h expected %h", dec[1], 8'h00); else pass_cnt++;
    @(negedge clk);
    rst_n   = 1'b1;
    en[0]   = 1'b1;
    vld[0]  = 1'b1;
    code[0] = 3'd2;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    total_cnt++; if (dec[0] !== 8'h0B) $display("FAIL hold_dec_al: got %h expected %h", dec[0], 8'h0B); else pass_cnt++;
    total_cnt++; if (act[0] !== 1'b1) $display("FAIL hold_act_al: got %b expected 1", act[0]); else pass_cnt++;
    // Reset in the middle of the low phase must act without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (dec[0] !== 8'h0F) $display("FAIL async_reset_dec: got %h expected %h", dec[0], 8'h0F); else pass_cnt++;
    total_cnt++; if (act[0] !== 1'b0) $display("FAIL async_reset_act: got %b expected 0", act[0]); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    en[0] = 1'b0;
  endtask

  task automatic test_level();
    @(negedge clk);
    en[1]   = 1'b1;
    vld[1]  = 1'b1;
    code[1] = 3'd5;
    @(posedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    total_cnt++; if (dec[1] !== 8'h20) $display("FAIL level_first: got %h expected %h", dec[1], 8'h20); else pass_cnt++;
    total_cnt++; if (act[1] !== 1'b1) $display("FAIL level_act: got %b expected 1", act[1]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dec[1] !== 8'h20) $display("FAIL level_hold: got %h expected %h", dec[1], 8'h20); else pass_cnt++;
    vld[1]  = 1'b1;
    code[1] = 3'd2;
    @(negedge clk);
    vld[1] = 1'b0;
    total_cnt++; if (dec[1] !== 8'h04) $display("FAIL level_replace: got %h expected %h", dec[1], 8'h04); else pass_cnt++;
    total_cnt++; if (dn[1] !== 1'b0) $display("FAIL level_no_done: got %b expected 0", dn[1]); else pass_cnt++;
    en[1] = 1'b0;
    #1;
    total_cnt++; if (rdy[1] !== 1'b0) $display("FAIL level_rdy_dis: got %b expected 0", rdy[1]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dec[1] !== 8'h00) $display("FAIL level_disable_dec: got %h expected %h", dec[1], 8'h00); else pass_cnt++;
    total_cnt++; if (act[1] !== 1'b0) $display("FAIL level_disable_act: got %b expected 0", act[1]); else pass_cnt++;
  endtask

  task automatic test_pulse_len();
    @(negedge clk);
    en[2]   = 1'b1;
    vld[2]  = 1'b1;
    code[2] = 3'd3;
    #1;
    total_cnt++; if (rdy[2] !== 1'b1) $display("FAIL pulse_rdy_idle: got %b expected 1", rdy[2]); else pass_cnt++;
    @(posedge clk);
    #1 code[2] = 3'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++; if (dec[2] !== 8'h08) $display("FAIL pulse_dec_%0d: got %h expected %h", k, dec[2], 8'h08); else pass_cnt++;
      total_cnt++; if (rdy[2] !== 1'b0) $display("FAIL pulse_rdy_%0d: got %b expected 0", k, rdy[2]); else pass_cnt++;
      total_cnt++; if (dn[2] !== 1'b0) $display("FAIL pulse_done_early_%0d: got %b expected 0", k, dn[2]); else pass_cnt++;
    end
    @(negedge clk);
    vld[2] = 1'b0;
    total_cnt++; if (dec[2] !== 8'h00) $display("FAIL pulse_end_dec: got %h expected %h", dec[2], 8'h00); else pass_cnt++;
    total_cnt++; if (dn[2] !== 1'b1) $display("FAIL pulse_done: got %b expected 1", dn[2]); else pass_cnt++;
    total_cnt++; if (act[2] !== 1'b0) $display("FAIL pulse_end_act: got %b expected 0", act[2]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dn[2] !== 1'b0) $display("FAIL pulse_done_width: got %b expected 0", dn[2]); else pass_cnt++;
    total_cnt++; if (dec[2] !== 8'h00) $display("FAIL pulse_no_capture: got %h expected %h", dec[2], 8'h00); else pass_cnt++;
    en[2] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [7];
    logic       exp_done;
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
    @(negedge clk);
    en[3]   = 1'b1;
    vld[3]  = 1'b1;
    code[3] = 3'd0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      exp_done = (j % 2 == 0);
      total_cnt++; if (dec[3] !== {4'b0, exp_seq[j-1]}) $display("FAIL b2b_dec_%0d: got %h expected %h", j, dec[3], {4'b0, exp_seq[j-1]}); else pass_cnt++;
      total_cnt++; if (dn[3] !== exp_done) $display("FAIL b2b_done_%0d: got %b expected %b", j, dn[3], exp_done); else pass_cnt++;
      if ((j % 2 == 1) && (j < 7)) code[3] = 3'((j + 1) / 2);
    end
    vld[3] = 1'b0;
    @(negedge clk);
    total_cnt++; if (dec[3] !== 8'h00) $display("FAIL b2b_last_dec: got %h expected %h", dec[3], 8'h00); else pass_cnt++;
    total_cnt++; if (dn[3] !== 1'b1) $display("FAIL b2b_last_done: got %b expected 1", dn[3]); else pass_cnt++;
    en[3] = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    en[4]   = 1'b1;
    vld[4]  = 1'b1;
    code[4] = 3'd1;
    @(posedge clk);
    @(negedge clk);
    vld[4] = 1'b0;
    total_cnt++; if (dec[4] !== 8'h02) $display("FAIL abort_dec_1: got %h expected %h", dec[4], 8'h02); else pass_cnt++;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      total_cnt++; if (dec[4] !== 8'h02) $display("FAIL abort_dec_%0d: got %h expected %h", k, dec[4], 8'h02); else pass_cnt++;
    end
    // Counter reached zero on the last edge; disable before the expiry edge.
    en[4] = 1'b0;
    #1;
    total_cnt++; if (rdy[4] !== 1'b0) $display("FAIL abort_rdy_pre: got %b expected 0", rdy[4]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dec[4] !== 8'h00) $display("FAIL abort_dec: got %h expected %h", dec[4], 8'h00); else pass_cnt++;
    total_cnt++; if (dn[4] !== 1'b0) $display("FAIL abort_done: got %b expected 0", dn[4]); else pass_cnt++;
    total_cnt++; if (act[4] !== 1'b0) $display("FAIL abort_act: got %b expected 0", act[4]); else pass_cnt++;
    total_cnt++; if (rdy[4] !== 1'b0) $display("FAIL abort_rdy: got %b expected 0", rdy[4]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dn[4] !== 1'b0) $display("FAIL abort_done_late: got %b expected 0", dn[4]); else pass_cnt++;
  endtask

  task automatic test_random(input int idx, input int pl, input int sel_w);
    dec_state_t m_state;
    logic [7:0] m_out;
    logic [7:0] oh;
    int         m_cnt;
    logic       m_done;
    logic       exp_act;
    logic       exp_rdy;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    m_state = IDLE;
    m_out   = 8'h00;
    m_cnt   = 0;
    m_done  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      exp_act = (m_state != IDLE);
      total_cnt++; if (dec[idx] !== m_out) $display("FAIL rand_pl%0d_dec_%0d: got %h expected %h", pl, i, dec[idx], m_out); else pass_cnt++;
      total_cnt++; if (dn[idx] !== m_done) $display("FAIL rand_pl%0d_done_%0d: got %b expected %b", pl, i, dn[idx], m_done); else pass_cnt++;
      total_cnt++; if (act[idx] !== exp_act) $display("FAIL rand_pl%0d_act_%0d: got %b expected %b", pl, i, act[idx], exp_act); else pass_cnt++;
      total_cnt++; if ($countones(dec[idx]) > 1) $display("FAIL rand_pl%0d_onehot_%0d: got %h expected at most one bit", pl, i, dec[idx]); else pass_cnt++;
      en[idx]   = ($urandom_range(0, 9) != 0);
      vld[idx]  = 1'($urandom_range(0, 1));
      code[idx] = 3'($urandom_range(0, (1 << sel_w) - 1));
      #1;
      exp_rdy = en[idx] && (m_state != PULSE);
      total_cnt++; if (rdy[idx] !== exp_rdy) $display("FAIL rand_pl%0d_rdy_%0d: got %b expected %b", pl, i, rdy[idx], exp_rdy); else pass_cnt++;
      @(posedge clk);
      oh = 8'h00;
      oh[code[idx]] = 1'b1;
      m_done = 1'b0;
      if (!en[idx]) begin
        m_state = IDLE;
        m_out   = 8'h00;
      end else begin
        case (m_state)
          IDLE: if (vld[idx]) begin
            m_out = oh;
            if (pl == 0) m_state = HOLD;
            else begin
              m_state = PULSE;
              m_cnt   = pl - 1;
            end
          end
          HOLD: if (vld[idx]) m_out = oh;
          PULSE: if (m_cnt == 0) begin
            m_state = IDLE;
            m_out   = 8'h00;
            m_done  = 1'b1;
          end else begin
            m_cnt = m_cnt - 1;
          end
          default: ;
        endcase
      end
    end
    @(negedge clk);
    en[idx]  = 1'b0;
    vld[idx] = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en[i]   = 1'b0;
      vld[i]  = 1'b0;
      code[i] = 3'd0;
    end
    test_reset();
    test_level();
    test_pulse_len();
    test_back_to_back();
    test_abort();
    test_random(1, 0, 3);
    test_random(3, 1, 2);
    test_random(5, 5, 2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
